// File: rtl/sequential_counter_param.sv
// Parametrised up/down counter with prescaler, wrap/saturate mode, preset load
// and a registered terminal-count pulse, presented on a pad-style io bus.
module sequential_counter_param #(
  parameter int unsigned     WIDTH      = 16,
  parameter longint unsigned MAX_COUNT  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     PRESCALE   = 1,
  parameter longint unsigned LOAD_VALUE = 0,
  parameter int unsigned     NUM_IO     = 16
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb
);

  localparam int unsigned      PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned      OB     = NUM_IO - 6;
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] LOAD_C = WIDTH'(LOAD_VALUE);
  localparam logic [PW-1:0]    P_LAST = PW'(PRESCALE - 1);

  logic clr, en, dn, ld, sat;
  assign clr = io_in[0];
  assign en  = io_in[1];
  assign dn  = io_in[2];
  assign ld  = io_in[3];
  assign sat = io_in[4];

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_eff;
  logic [WIDTH-1:0] count_step;
  logic [PW-1:0]    pcnt;
  logic             tc;
  logic             at_term;

  // An out-of-range count behaves exactly as if it were sitting at MAX_COUNT.
  assign count_eff = (count > MAX_C) ? MAX_C : count;
  assign at_term   = dn ? (count_eff == '0) : (count_eff == MAX_C);

  always_comb begin
    count_step = count_eff;
    if (dn) begin
      if (count_eff == '0) count_step = sat ? '0 : MAX_C;
      else                 count_step = count_eff - WIDTH'(1);
    end else begin
      if (count_eff == MAX_C) count_step = sat ? MAX_C : '0;
      else                    count_step = count_eff + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      pcnt  <= '0;
      tc    <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (clr) begin
        count <= '0;
        pcnt  <= '0;
      end else if (ld) begin
        count <= LOAD_C;
        pcnt  <= '0;
      end else if (en) begin
        if (pcnt != P_LAST) begin
          pcnt <= pcnt + PW'(1);
        end else begin
          pcnt  <= '0;
          count <= count_step;
          tc    <= at_term;
        end
      end
    end
  end

  logic [OB-1:0] cnt_pad;
  generate
    if (WIDTH >= OB) begin : g_trunc
      assign cnt_pad = count[OB-1:0];
    end else begin : g_ext
      assign cnt_pad = {{(OB-WIDTH){1'b0}}, count};
    end
  endgenerate

  assign io_out = {cnt_pad, tc, 5'b00000};
  assign io_oeb = {{(NUM_IO-5){1'b0}}, 5'b11111};

  // Upper pad inputs carry no function.
  logic unused_io;
  assign unused_io = ^io_in[NUM_IO-1:5];

endmodule

// File: doc/sequential_counter_param.md
# sequential_counter_param

Parametrised reference counter for fabric equivalence benches; it generalises the fixed 16-bit enabled counter. It adds configurable width, modulus, prescaler, up/down direction, wrap or saturate mode, a preset load and a registered terminal-count flag. It uses the same io_in / io_out / io_oeb pad-style interface, so a bench can compare it cycle-for-cycle against the same design mapped onto the eFPGA. Pins 0..4 are control inputs, pin 5 is the terminal-count output, and pins 6 and up carry the low count bits.

## Interface
- WIDTH, 16: counter width in bits; legal range 1..32.
- MAX_COUNT, 2**WIDTH-1: modulus top value; count range is 0..MAX_COUNT; must be ≤ 2**WIDTH-1.
- PRESCALE, 1: number of enabled cycles per count step; must be ≥ 1.
- LOAD_VALUE, 0: preset loaded by io_in[3]; must be ≤ MAX_COUNT.
- NUM_IO, 16: pad bus width; must be ≥ 7.
- CLK  input  1  single clock; all state changes on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- io_in  input  NUM_IO  control pins: [0] sync clear, [1] enable, [2] direction (0 = up, 1 = down), [3] load, [4] saturate mode (0 = wrap, 1 = saturate); bits above 4 are ignored.
- io_out  output  NUM_IO  [4:0] = 0; [5] = tc; [NUM_IO-1:6] = count[NUM_IO-7:0], zero-extended when WIDTH < NUM_IO-6.
- io_oeb  output  NUM_IO  constant: [4:0] = 1 (input), [NUM_IO-1:5] = 0 (output); independent of reset.

## Operation
- State: count[WIDTH-1:0], prescaler pcnt (ceil(log2(PRESCALE)) bits, minimum 1), tc flag.
- io_in is sampled directly at each rising CLK edge; there is no input synchronizer.
- Per-edge priority, highest first:
  - clear: count ← 0, pcnt ← 0, tc ← 0.
  - load: count ← LOAD_VALUE, pcnt ← 0, tc ← 0.
  - enable:
    - If pcnt ≠ PRESCALE-1: pcnt increments, count holds.
    - Otherwise pcnt ← 0 and a step is taken.
  - Otherwise: all state holds and tc ← 0.
- Step, up direction:
  - count < MAX_COUNT: count + 1.
  - count = MAX_COUNT: wrap mode gives 0; saturate mode holds MAX_COUNT.
- Step, down direction:
  - count > 0: count - 1.
  - count = 0: wrap mode gives MAX_COUNT; saturate mode holds 0.
- tc ← 1 exactly on a step taken while count is at the terminal value for the current direction (MAX_COUNT up, 0 down). On every other edge tc ← 0, so tc is a one-cycle pulse.
- In saturate mode, repeated steps at the terminal value raise tc on every step.
- Direction and mode changes take effect on the next edge, with no pipeline flush. The prescaler phase is preserved across direction changes.
- When count exceeds MAX_COUNT (only reachable through misparametrisation), it is treated as MAX_COUNT.
- With enable and clear both asserted, clear wins; pcnt does not advance.

## Timing
- Reset (resetn low, asynchronous): count = 0, pcnt = 0, tc = 0, io_out = all zeros immediately, without waiting for CLK.
- Reset release is sampled synchronously; the first state change occurs at the first rising edge with resetn high.
- Assertion mid-count aborts the sequence immediately, including while tc is high.
- Latency: a control sampled at edge N is visible on io_out after edge N, within the same cycle.
- Bench comparisons sample on the falling edge.
- Step rate: one step per PRESCALE enabled cycles. The first step after clear or load happens PRESCALE edges later.
- All outputs are registered or constant; there are no combinational paths from io_in to io_out.

## Test plan
- Reset: hold resetn low for 10 ns mid-operation → io_out = 0x0000 asynchronously; io_oeb = 0x001F at all times.
- Defaults: io_in = 0x0003 for 5 cycles, then 0x0002 for 100 cycles → count = 1, 2, … 100; io_out[15:6] tracks count[9:0]; tc stays 0.
- Wrap: MAX_COUNT = 9, io_in = 0x0002 → count 0…9, 0; tc = 1 only in the cycle count shows 0 after 9. Then io_in = 0x0006 from count 0 → count reads 9 next with tc = 1.
- Saturate: MAX_COUNT = 9, io_in = 0x0012 → count stops at 9; tc pulses on every subsequent enabled edge. Down-saturate (io_in = 0x0016) holds 0.
- Prescale and load: PRESCALE = 3, LOAD_VALUE = 5, pulse io_in = 0x0008 → count = 5. Then io_in = 0x0002 → count = 6 after 3 edges, 7 after 6. Setting enable = 0 for 2 cycles freezes both count and pcnt.
- Priority: io_in = 0x000B (clear + load + enable) → count = 0, tc = 0. Then io_in = 0x000A → count = LOAD_VALUE.
